superscalar_phys_reg_free_list: RTL

Multi-lane physical register free list for the wide dispatch_unit. It sits at core -> dispatch_unit -> superscalar_phys_reg_free_list. It provides up to DEQ_WIDTH free phys reg tags per cycle for renaming and accepts up to ENQ_WIDTH freed tags per cycle from commit. It keeps a checkpoint column FIFO of head pointers for branch restore, and lets one save be placed mid-bundle by lane.

---
 rtl/core_types_pkg.sv | 32 +++
 rtl/free_list_enq_compactor.sv | 26 ++
 rtl/superscalar_phys_reg_free_list.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/core_types_pkg.sv
// Shared core types: physical register tags, ROB indices and free list
// pointer/checkpoint records used by the rename-stage free lists.
package core_types_pkg;

  localparam int DEFAULT_NUM_PHYS_REGS      = 64;
  localparam int DEFAULT_NUM_ARCH_REGS      = 32;
  localparam int DEFAULT_DEQ_WIDTH          = 4;
  localparam int DEFAULT_ENQ_WIDTH          = 4;
  localparam int DEFAULT_CHECKPOINT_COLUMNS = 8;
  localparam int DEFAULT_ROB_DEPTH          = 64;

  localparam int PHYS_REG_TAG_W      = $clog2(DEFAULT_NUM_PHYS_REGS);
  localparam int ROB_INDEX_W         = $clog2(DEFAULT_ROB_DEPTH);
  localparam int CHECKPOINT_COLUMN_W = $clog2(DEFAULT_CHECKPOINT_COLUMNS);

  typedef logic [PHYS_REG_TAG_W-1:0]      phys_reg_tag_t;
  typedef logic [ROB_INDEX_W-1:0]         ROB_index_t;
  typedef logic [CHECKPOINT_COLUMN_W-1:0] checkpoint_column_t;

  // The extra msb distinguishes a full list from an empty one when indices match.
  typedef struct packed {
    logic          msb;
    phys_reg_tag_t index;
  } free_list_ptr_t;

  typedef struct packed {
    logic           valid;
    ROB_index_t     ROB_index;
    free_list_ptr_t head;
  } free_list_checkpoint_column_t;

endpackage

// File: rtl/free_list_enq_compactor.sv
// Prefix popcount over enqueue lanes: each lane's write offset from the tail
// and the total number of valid lanes.
module free_list_enq_compactor
  import core_types_pkg::*;
#(
  parameter int WIDTH = DEFAULT_ENQ_WIDTH,
  parameter int CNT_W = $clog2(DEFAULT_ENQ_WIDTH) + 1
) (
  input  logic [WIDTH-1:0]            valid,
  output logic [WIDTH-1:0][CNT_W-1:0] offset,
  output logic [CNT_W-1:0]            total
);

  logic [CNT_W-1:0] running;

  always_comb begin
    running = '0;
    offset  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      offset[i] = running;
      running   = running + CNT_W'(valid[i]);
    end
    total = running;
  end

endmodule

// File: rtl/superscalar_phys_reg_free_list.sv
// Multi-lane physical register free list with checkpointed head pointers
// for branch restore and exact-tag revert of the latest renames.
module superscalar_phys_reg_free_list
  import core_types_pkg::*;
#(
  parameter int NUM_PHYS_REGS      = DEFAULT_NUM_PHYS_REGS,
  parameter int NUM_ARCH_REGS      = DEFAULT_NUM_ARCH_REGS,
  parameter int DEQ_WIDTH          = DEFAULT_DEQ_WIDTH,
  parameter int ENQ_WIDTH          = DEFAULT_ENQ_WIDTH,
  parameter int CHECKPOINT_COLUMNS = DEFAULT_CHECKPOINT_COLUMNS,
  parameter int ROB_DEPTH          = DEFAULT_ROB_DEPTH
) (
  input  logic                                                CLK,
  input  logic                                                RST,
  output logic                                                DUT_error,
  input  logic [DEQ_WIDTH-1:0]                                dequeue_valid,
  output logic [DEQ_WIDTH-1:0][$clog2(NUM_PHYS_REGS)-1:0]     dequeue_phys_reg_tag,
  output logic [DEQ_WIDTH-1:0]                                dequeue_ready,
  input  logic [ENQ_WIDTH-1:0]                                enqueue_valid,
  input  logic [ENQ_WIDTH-1:0][$clog2(NUM_PHYS_REGS)-1:0]     enqueue_phys_reg_tag,
  output logic [$clog2(NUM_PHYS_REGS):0]                      free_count,
  output logic                                                full,
  output logic                                                empty,
  input  logic [$clog2(DEQ_WIDTH):0]                          revert_count,
  input  logic [DEQ_WIDTH-1:0][$clog2(NUM_PHYS_REGS)-1:0]     revert_speculated_dest_phys_reg_tag,
  input  logic                                                save_checkpoint_valid,
  input  logic [$clog2(DEQ_WIDTH)-1:0]                        save_checkpoint_lane,
  input  logic [$clog2(ROB_DEPTH)-1:0]                        save_checkpoint_ROB_index,
  output logic [$clog2(CHECKPOINT_COLUMNS)-1:0]               save_checkpoint_safe_column,
  input  logic                                                restore_checkpoint_valid,
  input  logic                                                restore_checkpoint_speculate_failed,
  input  logic [$clog2(ROB_DEPTH)-1:0]                        restore_checkpoint_ROB_index,
  input  logic [$clog2(CHECKPOINT_COLUMNS)-1:0]               restore_checkpoint_safe_column,
  output logic                                                restore_checkpoint_success
);

  localparam int TAG_W     = $clog2(NUM_PHYS_REGS);
  localparam int PTR_W     = TAG_W + 1;
  localparam int ROB_W     = $clog2(ROB_DEPTH);
  localparam int COL_W     = $clog2(CHECKPOINT_COLUMNS);
  localparam int DEQ_CNT_W = $clog2(DEQ_WIDTH) + 1;
  localparam int ENQ_CNT_W = $clog2(ENQ_WIDTH) + 1;

  logic [TAG_W-1:0] fl_array [NUM_PHYS_REGS];
  logic [PTR_W-1:0] head, tail, head_next, tail_next, count_next;

  logic             cp_valid [CHECKPOINT_COLUMNS];
  logic [ROB_W-1:0] cp_rob   [CHECKPOINT_COLUMNS];
  logic [PTR_W-1:0] cp_head  [CHECKPOINT_COLUMNS];
  logic [COL_W-1:0] cp_tail;

  logic [ENQ_WIDTH-1:0][ENQ_CNT_W-1:0] enq_offset;
  logic [ENQ_CNT_W-1:0]                enq_total;

  logic [DEQ_CNT_W-1:0] deq_take, save_take;
  logic                 prefix_on, deq_violation, revert_mismatch, enq_overflow;
  logic                 rs_match, restore_sf, revert_active, deq_active, error_next;

  free_list_enq_compactor #(
    .WIDTH (ENQ_WIDTH),
    .CNT_W (ENQ_CNT_W)
  ) u_enq_compactor (
    .valid  (enqueue_valid),
    .offset (enq_offset),
    .total  (enq_total)
  );

  always_comb begin
    for (int k = 0; k < DEQ_WIDTH; k++) begin
      dequeue_phys_reg_tag[k] = fl_array[head[TAG_W-1:0] + TAG_W'(k)];
      dequeue_ready[k]        = free_count > PTR_W'(k);
    end
  end

  // Only the contiguous ready prefix is consumed; gaps or unready lanes are violations.
  always_comb begin
    deq_take      = '0;
    save_take     = '0;
    deq_violation = 1'b0;
    prefix_on     = 1'b1;
    for (int k = 0; k < DEQ_WIDTH; k++) begin
      prefix_on = prefix_on & dequeue_valid[k] & dequeue_ready[k];
      deq_take  = deq_take + DEQ_CNT_W'(prefix_on);
      if (k <= int'(save_checkpoint_lane))
        save_take = save_take + DEQ_CNT_W'(prefix_on);
      if (dequeue_valid[k] && !dequeue_ready[k])
        deq_violation = 1'b1;
    end
    for (int k = 1; k < DEQ_WIDTH; k++) begin
      if (dequeue_valid[k] && !dequeue_valid[k-1])
        deq_violation = 1'b1;
    end
  end

  always_comb begin
    revert_mismatch = 1'b0;
    for (int j = 0; j < DEQ_WIDTH; j++) begin
      if ((DEQ_CNT_W'(j) < revert_count) &&
          (fl_array[head[TAG_W-1:0] - TAG_W'(j + 1)] != revert_speculated_dest_phys_reg_tag[j]))
        revert_mismatch = 1'b1;
    end
  end

  assign rs_match = cp_valid[restore_checkpoint_safe_column] &&
                    (cp_rob[restore_checkpoint_safe_column] == restore_checkpoint_ROB_index);
  assign restore_sf    = restore_checkpoint_valid && restore_checkpoint_speculate_failed;
  assign revert_active = !restore_sf && (revert_count != '0);
  assign deq_active    = !restore_sf && (revert_count == '0);
  assign restore_checkpoint_success = restore_checkpoint_valid && rs_match;
  assign enq_overflow  = int'(enq_total) > (NUM_PHYS_REGS - int'(free_count));

  always_comb begin
    head_next = head;
    if (restore_sf) begin
      if (rs_match)
        head_next = cp_head[restore_checkpoint_safe_column];
    end else if (revert_active) begin
      head_next = head - PTR_W'(revert_count);
    end else begin
      head_next = head + PTR_W'(deq_take);
    end
  end

  assign tail_next  = tail + PTR_W'(enq_total);
  assign count_next = tail_next - head_next;
  assign error_next = enq_overflow | (revert_active & revert_mismatch) | (deq_active & deq_violation);
  assign save_checkpoint_safe_column = cp_tail;

  always_ff @(posedge CLK) begin
    if (RST) begin
      head       <= {1'b0, TAG_W'(NUM_ARCH_REGS)};
      tail       <= {1'b1, {TAG_W{1'b0}}};
      free_count <= PTR_W'(NUM_PHYS_REGS - NUM_ARCH_REGS);
      full       <= 1'b0;
      empty      <= 1'b0;
      DUT_error  <= 1'b0;
    end else begin
      head       <= head_next;
      tail       <= tail_next;
      free_count <= count_next;
      full       <= (head_next[TAG_W-1:0] == tail_next[TAG_W-1:0]) && (head_next[TAG_W] != tail_next[TAG_W]);
      empty      <= (head_next[TAG_W-1:0] == tail_next[TAG_W-1:0]) && (head_next[TAG_W] == tail_next[TAG_W]);
      DUT_error  <= error_next;
    end
  end

  // Enqueue never bypasses into this cycle's dequeue lanes; writes land next cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_PHYS_REGS; i++)
        fl_array[i] <= TAG_W'(i);
    end else begin
      for (int i = 0; i < ENQ_WIDTH; i++) begin
        if (enqueue_valid[i])
          fl_array[tail[TAG_W-1:0] + TAG_W'(enq_offset[i])] <= enqueue_phys_reg_tag[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int c = 0; c < CHECKPOINT_COLUMNS; c++)
        cp_valid[c] <= 1'b0;
      cp_tail <= '0;
    end else if (restore_sf) begin
      if (rs_match) begin
        for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
          if (COL_W'(c) != restore_checkpoint_safe_column)
            cp_valid[c] <= 1'b0;
        end
        cp_tail <= restore_checkpoint_safe_column;
      end
    end else begin
      if (restore_checkpoint_valid && rs_match)
        cp_valid[restore_checkpoint_safe_column] <= 1'b0;
      // The branch lane's own rename is included so restore keeps it allocated.
      if (deq_active && save_checkpoint_valid) begin
        cp_valid[cp_tail] <= 1'b1;
        cp_rob[cp_tail]   <= save_checkpoint_ROB_index;
        cp_head[cp_tail]  <= head + PTR_W'(save_take);
        cp_tail           <= cp_tail + 1'b1;
      end
    end
  end

endmodule
